// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the byte-wide memory arbiter.
package mem_arbiter_pkg;

    localparam int          MA_ADDR_W  = 32;
    localparam logic [31:0] MA_IO_BASE = 32'h0003_0000;

    localparam logic [2:0] WIDTH_B = 3'b001;
    localparam logic [2:0] WIDTH_H = 3'b010;
    localparam logic [2:0] WIDTH_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_IF   = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    // Number of bytes for a data-port width code; unknown codes fall back to one byte.
    function automatic logic [2:0] width_to_bytes(input logic [2:0] code);
        logic [2:0] n;
        case (code)
            WIDTH_H: n = 3'd2;
            WIDTH_W: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Little-endian byte lane k of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owner of the byte-wide RAM/IO bus: arbitrates instruction fetch against the
// data port and breaks each request into back-to-back little-endian byte accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus idle; grant a pending request (round-robin on contention)
// ST_READ  | issuing byte addresses and capturing mem_din one cycle later
// ST_WRITE | driving store bytes; IO bytes wait while the UART buffer is full
// ST_DONE  | done pulse visible; no grant so the requester can drop its enable
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = MA_ADDR_W,
    parameter logic [31:0] IO_BASE = MA_IO_BASE
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_mem_en_in,
    input  logic [ADDR_W-1:0] if_mem_addr_in,
    output logic              mem_if_en_out,
    output logic [31:0]       mem_if_data_out,
    input  logic              datactrl_mem_en_in,
    input  logic              datactrl_mem_wr_in,
    input  logic [ADDR_W-1:0] datactrl_mem_addr_in,
    input  logic [2:0]        datactrl_mem_width_in,
    input  logic [31:0]       datactrl_mem_data_in,
    output logic              mem_datactrl_en_out,
    output logic [31:0]       mem_datactrl_data_out
);

    state_e              state_q;
    port_e               port_q;
    port_e               last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          nbytes_q;
    logic [31:0]         wdata_q;
    logic [31:0]         buf_q;
    logic [2:0]          a_cnt_q;
    logic [2:0]          r_cnt_q;
    logic                iss_q;
    logic                pend_q;

    logic [ADDR_W-1:0]   mem_a_q;
    logic [7:0]          mem_dout_q;
    logic                mem_wr_q;
    logic                if_done_q;
    logic [31:0]         if_data_q;
    logic                dc_done_q;
    logic [31:0]         dc_data_q;

    logic                grant_vld_d;
    port_e               grant_port_d;
    logic [ADDR_W-1:0]   req_addr_d;
    logic [2:0]          req_bytes_d;
    logic                req_wr_d;
    logic [31:0]         req_wdata_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [ADDR_W-1:0]   issue_addr_d;
    logic                wr_block_d;
    logic [31:0]         buf_d;

    // Grant selection, request mux and per-byte address/data helpers.
    always_comb begin
        grant_vld_d  = 1'b0;
        grant_port_d = PORT_IF;
        if (!flush_in) begin
            if (if_mem_en_in && datactrl_mem_en_in) begin
                grant_vld_d  = 1'b1;
                grant_port_d = (last_grant_q == PORT_IF) ? PORT_DATA : PORT_IF;
            end else if (datactrl_mem_en_in) begin
                grant_vld_d  = 1'b1;
                grant_port_d = PORT_DATA;
            end else if (if_mem_en_in) begin
                grant_vld_d  = 1'b1;
                grant_port_d = PORT_IF;
            end
        end

        if (grant_port_d == PORT_DATA) begin
            req_addr_d  = datactrl_mem_addr_in;
            req_bytes_d = width_to_bytes(datactrl_mem_width_in);
            req_wr_d    = datactrl_mem_wr_in;
            req_wdata_d = datactrl_mem_data_in;
        end else begin
            req_addr_d  = if_mem_addr_in;
            req_bytes_d = 3'd4;
            req_wr_d    = 1'b0;
            req_wdata_d = 32'h0;
        end

        next_addr_d  = addr_q + ADDR_W'(a_cnt_q);
        issue_addr_d = (state_q == ST_IDLE) ? req_addr_d : next_addr_d;
        wr_block_d   = io_buffer_full && (issue_addr_d[17:16] == IO_BASE[17:16]);

        buf_d = buf_q;
        buf_d[{r_cnt_q[1:0], 3'b000} +: 8] = mem_din;
    end

    // Main sequencer: grant, byte issue/capture, done pulses; frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT_IF;
            last_grant_q <= PORT_IF;
            addr_q       <= '0;
            nbytes_q     <= 3'd0;
            wdata_q      <= 32'h0;
            buf_q        <= 32'h0;
            a_cnt_q      <= 3'd0;
            r_cnt_q      <= 3'd0;
            iss_q        <= 1'b0;
            pend_q       <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'h0;
            mem_wr_q     <= 1'b0;
            if_done_q    <= 1'b0;
            if_data_q    <= 32'h0;
            dc_done_q    <= 1'b0;
            dc_data_q    <= 32'h0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_wr_q <= 1'b0;
                    if (grant_vld_d) begin
                        port_q       <= grant_port_d;
                        last_grant_q <= grant_port_d;
                        addr_q       <= req_addr_d;
                        nbytes_q     <= req_bytes_d;
                        wdata_q      <= req_wdata_d;
                        buf_q        <= 32'h0;
                        r_cnt_q      <= 3'd0;
                        pend_q       <= 1'b0;
                        mem_a_q      <= req_addr_d;
                        if (req_wr_d) begin
                            state_q <= ST_WRITE;
                            iss_q   <= 1'b0;
                            if (!wr_block_d) begin
                                mem_wr_q   <= 1'b1;
                                mem_dout_q <= req_wdata_d[7:0];
                                a_cnt_q    <= 3'd1;
                            end else begin
                                a_cnt_q    <= 3'd0;
                            end
                        end else begin
                            state_q <= ST_READ;
                            iss_q   <= 1'b1;
                            a_cnt_q <= 3'd1;
                        end
                    end
                end

                ST_READ: begin
                    mem_wr_q <= 1'b0;
                    if (flush_in) begin
                        state_q <= ST_IDLE;
                        iss_q   <= 1'b0;
                        pend_q  <= 1'b0;
                    end else begin
                        // mem_din lags mem_a by one cycle, so capture trails issue.
                        pend_q <= iss_q;
                        if (a_cnt_q < nbytes_q) begin
                            mem_a_q <= next_addr_d;
                            a_cnt_q <= a_cnt_q + 3'd1;
                            iss_q   <= 1'b1;
                        end else begin
                            iss_q   <= 1'b0;
                        end
                        if (pend_q) begin
                            buf_q   <= buf_d;
                            r_cnt_q <= r_cnt_q + 3'd1;
                            if (r_cnt_q == nbytes_q - 3'd1) begin
                                state_q <= ST_DONE;
                                if (port_q == PORT_IF) begin
                                    if_done_q <= 1'b1;
                                    if_data_q <= buf_d;
                                end else begin
                                    dc_done_q <= 1'b1;
                                    dc_data_q <= buf_d;
                                end
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    // Committed stores ignore flush and always run to completion.
                    if (a_cnt_q == nbytes_q) begin
                        state_q   <= ST_DONE;
                        mem_wr_q  <= 1'b0;
                        dc_done_q <= 1'b1;
                    end else if (!wr_block_d) begin
                        mem_a_q    <= next_addr_d;
                        mem_dout_q <= byte_of(wdata_q, a_cnt_q[1:0]);
                        mem_wr_q   <= 1'b1;
                        a_cnt_q    <= a_cnt_q + 3'd1;
                    end else begin
                        mem_wr_q   <= 1'b0;
                    end
                end

                ST_DONE: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end

                default: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_a                 = mem_a_q;
    assign mem_dout              = mem_dout_q;
    assign mem_wr                = mem_wr_q;
    assign mem_if_en_out         = if_done_q;
    assign mem_if_data_out       = if_data_q;
    assign mem_datactrl_en_out   = dc_done_q;
    assign mem_datactrl_data_out = dc_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_mem_en_in;
    logic [31:0] if_mem_addr_in;
    logic        mem_if_en_out;
    logic [31:0] mem_if_data_out;
    logic        datactrl_mem_en_in;
    logic        datactrl_mem_wr_in;
    logic [31:0] datactrl_mem_addr_in;
    logic [2:0]  datactrl_mem_width_in;
    logic [31:0] datactrl_mem_data_in;
    logic        mem_datactrl_en_out;
    logic [31:0] mem_datactrl_data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:65535];

    mem_arbiter dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .flush_in              (flush_in),
        .io_buffer_full        (io_buffer_full),
        .mem_din               (mem_din),
        .mem_dout              (mem_dout),
        .mem_a                 (mem_a),
        .mem_wr                (mem_wr),
        .if_mem_en_in          (if_mem_en_in),
        .if_mem_addr_in        (if_mem_addr_in),
        .mem_if_en_out         (mem_if_en_out),
        .mem_if_data_out       (mem_if_data_out),
        .datactrl_mem_en_in    (datactrl_mem_en_in),
        .datactrl_mem_wr_in    (datactrl_mem_wr_in),
        .datactrl_mem_addr_in  (datactrl_mem_addr_in),
        .datactrl_mem_width_in (datactrl_mem_width_in),
        .datactrl_mem_data_in  (datactrl_mem_data_in),
        .mem_datactrl_en_out   (mem_datactrl_en_out),
        .mem_datactrl_data_out (mem_datactrl_data_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM: read data appears the cycle after its address; writes land at the edge.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        checks++; if (mem_if_en_out !== 1'b0 || mem_datactrl_en_out !== 1'b0) begin
            errors++; $display("FAIL reset_done got if=%b dc=%b want 0/0", mem_if_en_out, mem_datactrl_en_out); end
        checks++; if (mem_if_data_out !== 32'h0) begin errors++; $display("FAIL reset_if_data got %h want 0", mem_if_data_out); end
        checks++; if (mem_datactrl_data_out !== 32'h0) begin errors++; $display("FAIL reset_dc_data got %h want 0", mem_datactrl_data_out); end
        rst_in = 1'b0;
    endtask

    task automatic test_if_read();
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        if_mem_addr_in = 32'h1000;
        if_mem_en_in   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c <= 4) begin
                checks++; if (mem_a !== 32'(32'h1000 + c - 1)) begin
                    errors++; $display("FAIL if_read_addr c=%0d got %h want %h", c, mem_a, 32'(32'h1000 + c - 1)); end
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL if_read_wr c=%0d got %b want 0", c, mem_wr); end
            end
            if (c == 5) begin
                checks++; if (mem_if_en_out !== 1'b0) begin errors++; $display("FAIL if_read_early_done got %b want 0", mem_if_en_out); end
            end
            if (c == 6) begin
                checks++; if (mem_if_en_out !== 1'b1) begin errors++; $display("FAIL if_read_done got %b want 1", mem_if_en_out); end
                checks++; if (mem_if_data_out !== 32'h0000_0513) begin
                    errors++; $display("FAIL if_read_data got %h want 00000513", mem_if_data_out); end
                if_mem_en_in = 1'b0;
            end
            if (c == 7) begin
                checks++; if (mem_if_en_out !== 1'b0) begin errors++; $display("FAIL if_read_pulse_len got %b want 0", mem_if_en_out); end
            end
        end
    endtask

    task automatic test_round_robin();
        ram[16'h2000] = 8'h78; ram[16'h2001] = 8'h56; ram[16'h2002] = 8'h34; ram[16'h2003] = 8'h12;
        if_mem_addr_in        = 32'h1000;
        if_mem_en_in          = 1'b1;
        datactrl_mem_addr_in  = 32'h2000;
        datactrl_mem_wr_in    = 1'b0;
        datactrl_mem_width_in = 3'b100;
        datactrl_mem_en_in    = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) begin
                checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL rr_data_first got %h want 00002000", mem_a); end
            end
            if (c == 6) begin
                checks++; if (mem_datactrl_en_out !== 1'b1 || mem_if_en_out !== 1'b0) begin
                    errors++; $display("FAIL rr_lw_done got dc=%b if=%b want 1/0", mem_datactrl_en_out, mem_if_en_out); end
                checks++; if (mem_datactrl_data_out !== 32'h1234_5678) begin
                    errors++; $display("FAIL rr_lw_data got %h want 12345678", mem_datactrl_data_out); end
                datactrl_mem_en_in = 1'b0;
            end
            if (c == 8) begin
                checks++; if (mem_a !== 32'h1000) begin errors++; $display("FAIL rr_if_second got %h want 00001000", mem_a); end
            end
            if (c == 13) begin
                checks++; if (mem_if_en_out !== 1'b1 || mem_if_data_out !== 32'h0000_0513) begin
                    errors++; $display("FAIL rr_if_done got en=%b data=%h want 1/00000513", mem_if_en_out, mem_if_data_out); end
                if_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_store_half();
        datactrl_mem_addr_in  = 32'h2002;
        datactrl_mem_wr_in    = 1'b1;
        datactrl_mem_width_in = 3'b010;
        datactrl_mem_data_in  = 32'hABCD_1234;
        datactrl_mem_en_in    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h2002 || mem_dout !== 8'h34) begin
                    errors++; $display("FAIL sh_byte0 got wr=%b a=%h d=%h want 1/00002002/34", mem_wr, mem_a, mem_dout); end
            end
            if (c == 2) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h2003 || mem_dout !== 8'h12) begin
                    errors++; $display("FAIL sh_byte1 got wr=%b a=%h d=%h want 1/00002003/12", mem_wr, mem_a, mem_dout); end
            end
            if (c == 3) begin
                checks++; if (mem_datactrl_en_out !== 1'b1 || mem_wr !== 1'b0) begin
                    errors++; $display("FAIL sh_done got en=%b wr=%b want 1/0", mem_datactrl_en_out, mem_wr); end
                checks++; if (ram[16'h2003] !== 8'h12) begin errors++; $display("FAIL sh_ram got %h want 12", ram[16'h2003]); end
                datactrl_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_io_backpressure();
        datactrl_mem_addr_in  = 32'h0003_0000;
        datactrl_mem_wr_in    = 1'b1;
        datactrl_mem_width_in = 3'b001;
        datactrl_mem_data_in  = 32'h0000_0041;
        datactrl_mem_en_in    = 1'b1;
        io_buffer_full        = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c <= 5) begin
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_blocked c=%0d got wr=%b want 0", c, mem_wr); end
            end
            if (c == 5) io_buffer_full = 1'b0;
            if (c == 6) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41) begin
                    errors++; $display("FAIL io_write got wr=%b a=%h d=%h want 1/00030000/41", mem_wr, mem_a, mem_dout); end
                checks++; if (mem_datactrl_en_out !== 1'b0) begin errors++; $display("FAIL io_early_done got %b want 0", mem_datactrl_en_out); end
            end
            if (c == 7) begin
                checks++; if (mem_datactrl_en_out !== 1'b1) begin errors++; $display("FAIL io_done got %b want 1", mem_datactrl_en_out); end
                datactrl_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_flush_read();
        if_mem_addr_in = 32'h1000;
        if_mem_en_in   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c <= 9) begin
                checks++; if (mem_if_en_out !== 1'b0 || mem_wr !== 1'b0) begin
                    errors++; $display("FAIL flush_no_done c=%0d got en=%b wr=%b want 0/0", c, mem_if_en_out, mem_wr); end
            end
            if (c == 3) begin flush_in = 1'b1; if_mem_addr_in = 32'h2000; end
            if (c == 4) flush_in = 1'b0;
            if (c == 5) begin
                checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL flush_regrant got %h want 00002000", mem_a); end
            end
            if (c == 10) begin
                checks++; if (mem_if_en_out !== 1'b1 || mem_if_data_out !== 32'h1234_5678) begin
                    errors++; $display("FAIL flush_refetch got en=%b data=%h want 1/12345678", mem_if_en_out, mem_if_data_out); end
                if_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_flush_write();
        logic [31:0] wword;
        wword = 32'hDEAD_BEEF;
        datactrl_mem_addr_in  = 32'h3000;
        datactrl_mem_wr_in    = 1'b1;
        datactrl_mem_width_in = 3'b100;
        datactrl_mem_data_in  = wword;
        datactrl_mem_en_in    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c <= 4) begin
                checks++; if (mem_wr !== 1'b1 || mem_a !== 32'(32'h3000 + c - 1) || mem_dout !== wword[8*(c-1) +: 8]) begin
                    errors++; $display("FAIL flushw_byte c=%0d got wr=%b a=%h d=%h want 1/%h/%h",
                                       c, mem_wr, mem_a, mem_dout, 32'(32'h3000 + c - 1), wword[8*(c-1) +: 8]); end
            end
            if (c == 2) flush_in = 1'b1;
            if (c == 3) flush_in = 1'b0;
            if (c == 5) begin
                checks++; if (mem_datactrl_en_out !== 1'b1) begin errors++; $display("FAIL flushw_done got %b want 1", mem_datactrl_en_out); end
                datactrl_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_rdy_stall();
        ram[16'h0010] = 8'hA5;
        datactrl_mem_addr_in  = 32'h10;
        datactrl_mem_wr_in    = 1'b0;
        datactrl_mem_width_in = 3'b001;
        datactrl_mem_en_in    = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c <= 4) begin
                checks++; if (mem_a !== 32'h10) begin errors++; $display("FAIL stall_addr c=%0d got %h want 00000010", c, mem_a); end
            end
            if (c <= 5) begin
                checks++; if (mem_datactrl_en_out !== 1'b0) begin errors++; $display("FAIL stall_early c=%0d got %b want 0", c, mem_datactrl_en_out); end
            end
            if (c == 1) rdy_in = 1'b0;
            if (c == 4) rdy_in = 1'b1;
            if (c == 6) begin
                checks++; if (mem_datactrl_en_out !== 1'b1 || mem_datactrl_data_out !== 32'h0000_00A5) begin
                    errors++; $display("FAIL stall_done got en=%b data=%h want 1/000000a5", mem_datactrl_en_out, mem_datactrl_data_out); end
                datactrl_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_illegal_width();
        ram[16'h0011] = 8'h5A;
        datactrl_mem_addr_in  = 32'h11;
        datactrl_mem_wr_in    = 1'b0;
        datactrl_mem_width_in = 3'b011;
        datactrl_mem_en_in    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 2) begin
                checks++; if (mem_a !== 32'h11 || mem_datactrl_en_out !== 1'b0) begin
                    errors++; $display("FAIL illw_single got a=%h en=%b want 00000011/0", mem_a, mem_datactrl_en_out); end
            end
            if (c == 3) begin
                checks++; if (mem_datactrl_en_out !== 1'b1 || mem_datactrl_data_out !== 32'h0000_005A) begin
                    errors++; $display("FAIL illw_done got en=%b data=%h want 1/0000005a", mem_datactrl_en_out, mem_datactrl_data_out); end
                datactrl_mem_en_in = 1'b0;
            end
        end
    endtask

    task automatic test_wrap();
        ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;
        if_mem_addr_in = 32'hFFFF_FFFE;
        if_mem_en_in   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 3) begin
                checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 00000000", mem_a); end
            end
            if (c == 6) begin
                checks++; if (mem_if_en_out !== 1'b1 || mem_if_data_out !== 32'h4433_2211) begin
                    errors++; $display("FAIL wrap_data got en=%b data=%h want 1/44332211", mem_if_en_out, mem_if_data_out); end
                if_mem_en_in = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        rst_in                = 1'b1;
        rdy_in                = 1'b1;
        flush_in              = 1'b0;
        io_buffer_full        = 1'b0;
        if_mem_en_in          = 1'b0;
        if_mem_addr_in        = 32'h0;
        datactrl_mem_en_in    = 1'b0;
        datactrl_mem_wr_in    = 1'b0;
        datactrl_mem_addr_in  = 32'h0;
        datactrl_mem_width_in = 3'b001;
        datactrl_mem_data_in  = 32'h0;

        test_reset();
        test_if_read();
        test_round_robin();
        test_store_half();
        test_io_backpressure();
        test_flush_read();
        test_flush_write();
        test_rdy_stall();
        test_illegal_width();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
